mem_responder: RTL

Unified instruction/data memory slave for the multicycle MIPS core: the responding end of the controller's memory interface (fetch, LW, SW). It accepts one request at a time over a Req/Ready handshake, inserts a fixed number of wait states, then performs a word read or write and returns a one-cycle Ready pulse. It replaces the zero-latency memory model so the controller FSM can be exercised against realistic memory timing.

---
 rtl/mem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory slave with fixed wait states and a one-cycle Ready pulse.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to reject misaligned accesses (no access performed, Err pulses with Ready).
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Ready,
    output logic        Busy,
    output logic        Err,
    output logic [1:0]  dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lat_we;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic          misaligned;
    logic          mem_we;
    logic [31:0]   mem [DEPTH];

    // Handshake: Req is sampled only in IDLE; the request is then owned by the slave until
    // Ready pulses for one cycle. Inputs are latched at acceptance and ignored afterwards.

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic [1:0] lat_off;
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            lat_off <= 2'b00;
        end else if (state == IDLE && Req) begin
            lat_off <= Addr[1:0];
        end
    end
    assign misaligned = (lat_off != 2'b00);
    logic unused_addr;
    assign unused_addr = ^Addr[31:AW+2];
`else
    assign misaligned = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{Addr[31:AW+2], Addr[1:0]};
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            Ready     <= 1'b0;
            Busy      <= 1'b0;
            Err       <= 1'b0;
            RData     <= 32'h0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'h0;
        end else begin
            Ready <= 1'b0;
            Err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req) begin
                        lat_we    <= We;
                        lat_idx   <= Addr[AW+1:2];
                        lat_wdata <= WData;
                        cnt       <= CW'(LATENCY - 1);
                        Busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        Ready <= 1'b1;
                        Err   <= misaligned;
                        state <= RESP;
                        if (!lat_we && !misaligned) begin
                            RData <= mem[lat_idx];
                        end
                    end
                end
                RESP: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Gated by Reset_n so a write in flight when reset hits never reaches the array.
    assign mem_we = Reset_n && (state == WAIT) && (cnt == '0) && lat_we && !misaligned;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    assign dbg_state = state;

endmodule
